complex_as_mul_unit: RTL and testbench

- Registered complex-number arithmetic unit for the datapath ALU.
- Each operand packs one complex value: real part in the upper half, imaginary part in the lower half, each a PART_LEN-bit signed two's-complement integer.
- Performs complex add, subtract or multiply, selected by a 2-bit control word.
- Result is registered with one-cycle latency and a valid flag.

---
 rtl/complex_as_mul_unit_if.sv | 11 +
 rtl/complex_as_mul_unit.sv | 59 +++++
 tb/tb_complex_as_mul_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/complex_as_mul_unit_if.sv
// complex_as_mul_unit_if: operand/result bus for the complex arithmetic unit.
interface complex_as_mul_unit_if #(parameter int PART_LEN = 8);
    logic [2*PART_LEN-1:0] a;
    logic [2*PART_LEN-1:0] b;
    logic [1:0]            control_sig;
    logic                  in_valid;
    logic [2*PART_LEN-1:0] res;
    logic                  out_valid;
    modport master (output a, b, control_sig, in_valid, input res, out_valid);
    modport slave (input a, b, control_sig, in_valid, output res, out_valid);
endinterface

// File: rtl/complex_as_mul_unit.sv
// complex_as_mul_unit: registered complex add/sub/multiply, one-cycle latency.
// Define CPLX_SATURATE_EN to clamp each result part instead of wrapping.
module complex_as_mul_unit #(
    parameter int PART_LEN = 8
) (
    input logic clk,
    input logic rstn,
    complex_as_mul_unit_if.slave bus
);
    localparam int P = PART_LEN;
    localparam int W = 2*P+1;
`ifdef CPLX_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic signed [P-1:0] ar, ai, br, bi;
    logic signed [2*P-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [2*P-1:0] p_rr, p_ii, p_ri, p_ir;
    logic [W-1:0] mul_re, mul_im, sum_re, sum_im;
    logic [P:0] br_n, bi_n, as_re, as_im;
    logic [2*P-1:0] next_res;
    assign ar = bus.a[2*P-1:P];
    assign ai = bus.a[P-1:0];
    assign br = bus.b[2*P-1:P];
    assign bi = bus.b[P-1:0];
    assign ar_x = {{P{ar[P-1]}}, ar};
    assign ai_x = {{P{ai[P-1]}}, ai};
    assign br_x = {{P{br[P-1]}}, br};
    assign bi_x = {{P{bi[P-1]}}, bi};
    assign p_rr = ar_x * br_x;
    assign p_ii = ai_x * bi_x;
    assign p_ri = ar_x * bi_x;
    assign p_ir = ai_x * br_x;
    assign mul_re = {p_rr[2*P-1], p_rr} - {p_ii[2*P-1], p_ii};
    assign mul_im = {p_ri[2*P-1], p_ri} + {p_ir[2*P-1], p_ir};
    // One guard bit keeps -(-2^(P-1)) representable on subtract
    assign br_n = bus.control_sig[0] ? -{br[P-1], br} : {br[P-1], br};
    assign bi_n = bus.control_sig[0] ? -{bi[P-1], bi} : {bi[P-1], bi};
    assign as_re = {ar[P-1], ar} + br_n;
    assign as_im = {ai[P-1], ai} + bi_n;
    assign sum_re = bus.control_sig[1] ? {{P{as_re[P]}}, as_re} : mul_re;
    assign sum_im = bus.control_sig[1] ? {{P{as_im[P]}}, as_im} : mul_im;
    function automatic logic [P-1:0] fit(input logic [W-1:0] v);
        return (SAT && !(&v[W-1:P-1]) && (|v[W-1:P-1]))
            ? (v[W-1] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}})
            : v[P-1:0];
    endfunction
    assign next_res = {fit(sum_re), fit(sum_im)};
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.res       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.res <= next_res;
        end
    end
endmodule

// File: tb/tb_complex_as_mul_unit.sv
// tb_complex_as_mul_unit: scoreboard bench with a behavioural complex-arithmetic model.
module tb_complex_as_mul_unit;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [15:0] last_res = '0;
    typedef struct { logic [15:0] res; int cyc; } exp_t;
    exp_t sb[$];

    complex_as_mul_unit_if #(.PART_LEN(8)) bus ();
    complex_as_mul_unit #(.PART_LEN(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [7:0] fix(input int v);
`ifdef CPLX_SATURATE_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`endif
        return 8'(v);
    endfunction

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] c);
        int ar, ai, br, bi, re, im;
        ar = int'($signed(a[15:8]));
        ai = int'($signed(a[7:0]));
        br = int'($signed(b[15:8]));
        bi = int'($signed(b[7:0]));
        if (c[1]) begin
            re = c[0] ? ar - br : ar + br;
            im = c[0] ? ai - bi : ai + bi;
        end else begin
            re = ar * br - ai * bi;
            im = ar * bi + ai * br;
        end
        return {fix(re), fix(im)};
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res", 32'(bus.res), 32'(e.res));
                    chk("latency", 32'(cyc), 32'(e.cyc + 1));
                    last_res = e.res;
                end
            end else chk("idle_hold", 32'(bus.res), 32'(last_res));
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] c);
        bus.a = a;
        bus.b = b;
        bus.control_sig = c;
        bus.in_valid = 1'b1;
        sb.push_back('{res: model(a, b, c), cyc: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.control_sig = 2'($urandom);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rnd_part();
        int s;
        s = $urandom_range(0, 5);
        return s == 0 ? 8'h80 : s == 1 ? 8'h7F : 8'($urandom);
    endfunction

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.control_sig = '0;
        bus.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("reset_res", 32'(bus.res), 32'd0);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        idle();
        idle();
        issue(16'h0302, 16'h0104, 2'b10);
        idle();
        issue(16'h0302, 16'h0104, 2'b11);
        issue(16'h0302, 16'h0104, 2'b00);
        issue(16'h0302, 16'h0104, 2'b01);
        idle();
        issue(16'h6400, 16'h6400, 2'b10);
        issue(16'h8000, 16'h8000, 2'b00);
        issue(16'h8080, 16'h7F7F, 2'b11);
        issue(16'h7F80, 16'h7F80, 2'b00);
        idle();
        issue(16'h0302, 16'h0104, 2'b10);
        issue(16'h0302, 16'h0104, 2'b11);
        issue(16'h0302, 16'h0104, 2'b00);
        issue(16'h0302, 16'h0104, 2'b10);
        bus.a = 16'h1234;
        bus.b = 16'h5678;
        bus.control_sig = 2'b00;
        bus.in_valid = 1'b1;
        #2 rstn = 1'b0;
        sb.delete();
        last_res = '0;
        #1;
        chk("midreset_res", 32'(bus.res), 32'd0);
        chk("midreset_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        idle();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) issue({rnd_part(), rnd_part()}, {rnd_part(), rnd_part()}, 2'($urandom));
            else idle();
        end
        repeat (3) idle();
        chk("drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
